// File: rtl/jkr_cport_dpkt_ingress_pack.sv
// Packs a 32-bit ingress beat stream into 512-bit lines with odd chunk/address
// parity and holds each line on the packet-memory write port until acknowledged.
module jkr_cport_dpkt_ingress_pack #(
  parameter int ADDR_WIDTH     = 10,
  parameter int BEAT_WIDTH     = 32,
  parameter int BEATS_PER_LINE = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                 i_core_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_beat_valid,
  output logic                                 o_beat_ready,
  input  logic [BEAT_WIDTH-1:0]                i_beat_data,
  input  logic                                 i_beat_first,
  input  logic                                 i_beat_last,
  input  logic [ADDR_WIDTH-1:0]                i_line_addr,
  output logic                                 o_wr_valid,
  output logic [ADDR_WIDTH-1:0]                o_core_addr,
  output logic [BEAT_WIDTH*BEATS_PER_LINE-1:0] o_data,
  output logic [BEATS_PER_LINE-1:0]            o_data_parity,
  output logic                                 o_addr_parity,
  input  logic                                 i_wr_ack,
  input  logic                                 i_inj_addr_par_err,
  input  logic [BEATS_PER_LINE-1:0]            i_inj_data_par_err,
  output logic [CNT_WIDTH-1:0]                 o_line_cnt,
  output logic [CNT_WIDTH-1:0]                 o_proto_err_cnt,
  output logic                                 o_busy,
  output logic [1:0]                           o_dbg_state
);

  // Handshakes: a beat moves on a rising edge where i_beat_valid && o_beat_ready;
  // a line is retired on a rising edge where o_wr_valid && i_wr_ack.

  localparam int DATA_WIDTH = BEAT_WIDTH * BEATS_PER_LINE;
  localparam int IDX_W      = $clog2(BEATS_PER_LINE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]     buf_q, buf_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [BEATS_PER_LINE-1:0] par_q, par_nxt;
  logic                      apar_q;
  logic [BEATS_PER_LINE-1:0] inj_data_q;
  logic                      inj_addr_q;
  logic [CNT_WIDTH-1:0]      line_cnt_q, err_cnt_q;
  logic                      xfer, proto_err, line_done, enter_pend;

  assign o_beat_ready = (state_q != PEND);
  assign xfer         = i_beat_valid && o_beat_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    addr_d    = addr_q;
    proto_err = 1'b0;
    line_done = 1'b0;
    case (state_q)
      IDLE, FILL: begin
        if (xfer) begin
          if (i_beat_first) begin
            // A first beat always starts a fresh line; mid-line it is a restart.
            proto_err                 = (state_q == FILL);
            addr_d                    = i_line_addr;
            buf_d                     = '0;
            buf_d[0 +: BEAT_WIDTH]    = i_beat_data;
            idx_d                     = IDX_W'(1);
            state_d                   = i_beat_last ? PEND : FILL;
          end else if (state_q == IDLE) begin
            proto_err = 1'b1;
          end else begin
            buf_d[idx_q*BEAT_WIDTH +: BEAT_WIDTH] = i_beat_data;
            idx_d = idx_q + IDX_W'(1);
            if (i_beat_last || (idx_q == IDX_W'(BEATS_PER_LINE-1)))
              state_d = PEND;
          end
        end
      end
      PEND: begin
        if (i_wr_ack) begin
          line_done = 1'b1;
          idx_d     = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_pend = (state_d == PEND) && (state_q != PEND);

  always_comb begin
    par_nxt = '0;
    for (int k = 0; k < BEATS_PER_LINE; k++)
      par_nxt[k] = ~^buf_d[k*BEAT_WIDTH +: BEAT_WIDTH];
  end

  always_ff @(posedge i_core_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      addr_q     <= '0;
      par_q      <= '0;
      apar_q     <= 1'b0;
      inj_data_q <= '0;
      inj_addr_q <= 1'b0;
      line_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      if (enter_pend) begin
        par_q      <= par_nxt;
        apar_q     <= ~^addr_d;
        inj_data_q <= i_inj_data_par_err;
        inj_addr_q <= i_inj_addr_par_err;
      end else if (line_done) begin
        inj_data_q <= '0;
        inj_addr_q <= 1'b0;
      end
      if (line_done && (line_cnt_q != '1))
        line_cnt_q <= line_cnt_q + CNT_WIDTH'(1);
      if (proto_err && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_wr_valid      = (state_q == PEND);
  assign o_core_addr     = addr_q;
  assign o_data          = buf_q;
  // Injection masks live beside the golden parity so they drop away on ack.
  assign o_data_parity   = par_q ^ inj_data_q;
  assign o_addr_parity   = apar_q ^ inj_addr_q;
  assign o_line_cnt      = line_cnt_q;
  assign o_proto_err_cnt = err_cnt_q;
  assign o_busy          = (state_q != IDLE);
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_jkr_cport_dpkt_ingress_pack.sv
// Directed plus randomized bench for jkr_cport_dpkt_ingress_pack against a
// line-level reference model.
module tb_jkr_cport_dpkt_ingress_pack;

  localparam int AW  = 10;
  localparam int BW  = 32;
  localparam int BPL = 16;
  localparam int CW  = 16;
  localparam int DW  = BW * BPL;
  localparam int LW  = 1 + AW + BPL + DW;

  logic           clk = 1'b0;
  logic           i_reset_n = 1'b0;
  logic           i_beat_valid = 1'b0;
  logic           o_beat_ready;
  logic [BW-1:0]  i_beat_data = '0;
  logic           i_beat_first = 1'b0;
  logic           i_beat_last = 1'b0;
  logic [AW-1:0]  i_line_addr = '0;
  logic           o_wr_valid;
  logic [AW-1:0]  o_core_addr;
  logic [DW-1:0]  o_data;
  logic [BPL-1:0] o_data_parity;
  logic           o_addr_parity;
  logic           i_wr_ack = 1'b0;
  logic           i_inj_addr_par_err = 1'b0;
  logic [BPL-1:0] i_inj_data_par_err = '0;
  logic [CW-1:0]  o_line_cnt;
  logic [CW-1:0]  o_proto_err_cnt;
  logic           o_busy;
  logic [1:0]     o_dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  jkr_cport_dpkt_ingress_pack #(
    .ADDR_WIDTH(AW), .BEAT_WIDTH(BW), .BEATS_PER_LINE(BPL), .CNT_WIDTH(CW)
  ) dut (
    .i_core_clk(clk), .i_reset_n(i_reset_n),
    .i_beat_valid(i_beat_valid), .o_beat_ready(o_beat_ready),
    .i_beat_data(i_beat_data), .i_beat_first(i_beat_first),
    .i_beat_last(i_beat_last), .i_line_addr(i_line_addr),
    .o_wr_valid(o_wr_valid), .o_core_addr(o_core_addr), .o_data(o_data),
    .o_data_parity(o_data_parity), .o_addr_parity(o_addr_parity),
    .i_wr_ack(i_wr_ack), .i_inj_addr_par_err(i_inj_addr_par_err),
    .i_inj_data_par_err(i_inj_data_par_err), .o_line_cnt(o_line_cnt),
    .o_proto_err_cnt(o_proto_err_cnt), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [BW-1:0] cur_beats[$];
  logic [AW-1:0] cur_addr;
  bit            in_line = 0;
  int            exp_err = 0;
  int            exp_lines = 0;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] cur_exp;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    cur_beats.delete();
    in_line   = 0;
    exp_err   = 0;
    exp_lines = 0;
    exp_q.delete();
  endfunction

  function automatic void model_close();
    logic [DW-1:0]  d;
    logic [BPL-1:0] p;
    logic           ap;
    d = '0;
    foreach (cur_beats[i]) d[i*BW +: BW] = cur_beats[i];
    for (int k = 0; k < BPL; k++)
      p[k] = (($countones(d[k*BW +: BW]) % 2) == 0) ^ i_inj_data_par_err[k];
    ap = (($countones(cur_addr) % 2) == 0) ^ i_inj_addr_par_err;
    exp_q.push_back({ap, cur_addr, p, d});
    cur_beats.delete();
    in_line = 0;
  endfunction

  function automatic void model_beat(input logic [BW-1:0] data, input bit first,
                                     input bit last, input logic [AW-1:0] addr);
    if (first) begin
      if (in_line) exp_err++;
      in_line  = 1;
      cur_addr = addr;
      cur_beats.delete();
      cur_beats.push_back(data);
    end else if (!in_line) begin
      exp_err++;
      return;
    end else begin
      cur_beats.push_back(data);
    end
    if (last || cur_beats.size() == BPL) model_close();
  endfunction

  // driver tasks (inputs change just after the falling edge)
  task automatic send_beat(input logic [BW-1:0] data, input bit first,
                           input bit last, input logic [AW-1:0] addr);
    int n = 0;
    while (!o_beat_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_beat_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    i_beat_valid = 1'b1;
    i_beat_data  = data;
    i_beat_first = first;
    i_beat_last  = last;
    i_line_addr  = addr;
    model_beat(data, first, last, addr);
    @(negedge clk);
    i_beat_valid = 1'b0;
    i_beat_first = 1'b0;
    i_beat_last  = 1'b0;
  endtask

  // mode 0: beat k = k, 1: all ones, 2: zeros, 3: random
  task automatic send_line(input logic [AW-1:0] addr, input int n, input int mode,
                           input bit last_on_end);
    logic [BW-1:0] d;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: d = BW'(i);
        1: d = '1;
        2: d = '0;
        default: d = $urandom;
      endcase
      send_beat(d, i == 0, last_on_end && (i == n - 1), addr);
    end
  endtask

  task automatic chk_line(input string tag);
    chk({tag, "_addr"}, o_core_addr, cur_exp[DW+BPL +: AW]);
    chk({tag, "_data"}, o_data, cur_exp[DW-1:0]);
    chk({tag, "_dpar"}, o_data_parity, cur_exp[DW +: BPL]);
    chk({tag, "_apar"}, o_addr_parity, cur_exp[LW-1]);
  endtask

  task automatic expect_line(input string tag, input int hold);
    int n = 0;
    while (!o_wr_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wr_valid"}, o_wr_valid, 1);
    if (exp_q.size() == 0) begin
      chk({tag, "_exp_empty"}, 0, 1);
      return;
    end
    cur_exp = exp_q.pop_front();
    chk_line(tag);
    for (int h = 0; h < hold; h++) begin
      // offered beats must be refused while the line is pending
      i_beat_valid = 1'b1;
      i_beat_first = 1'b1;
      i_beat_data  = $urandom;
      @(negedge clk);
      chk({tag, "_hold_ready"}, o_beat_ready, 0);
      chk({tag, "_hold_valid"}, o_wr_valid, 1);
      chk_line({tag, "_hold"});
    end
    i_beat_valid = 1'b0;
    i_beat_first = 1'b0;
    i_wr_ack = 1'b1;
    @(negedge clk);
    i_wr_ack = 1'b0;
    exp_lines++;
    chk({tag, "_ack_drop"}, o_wr_valid, 0);
    chk({tag, "_line_cnt"}, o_line_cnt, CW'(exp_lines));
    chk({tag, "_err_cnt"}, o_proto_err_cnt, CW'(exp_err));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_valid"}, o_wr_valid, 0);
    chk({tag, "_data"}, o_data, 0);
    chk({tag, "_dpar"}, o_data_parity, 0);
    chk({tag, "_apar"}, o_addr_parity, 0);
    chk({tag, "_addr"}, o_core_addr, 0);
    chk({tag, "_line_cnt"}, o_line_cnt, 0);
    chk({tag, "_err_cnt"}, o_proto_err_cnt, 0);
    chk({tag, "_ready"}, o_beat_ready, 1);
    chk({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic async_reset(input string tag);
    #2 i_reset_n = 1'b0;
    #1 chk_reset_vals(tag);
    model_clear();
    @(negedge clk);
    i_reset_n = 1'b1;
  endtask

  // directed sequence followed by randomized lines
  initial begin
    #1 chk_reset_vals("por");
    repeat (2) @(negedge clk);
    i_reset_n = 1'b1;
    @(negedge clk);

    send_line(10'h155, 16, 0, 1'b1);
    chk("full_dpar_const", o_data_parity, 16'h9669);
    chk("full_apar_const", o_addr_parity, 0);
    expect_line("full16", 0);

    send_line(10'h0a3, 3, 1, 1'b1);
    chk("short_dpar_const", o_data_parity, 16'hffff);
    expect_line("short", 0);

    send_line(10'h3c0, 5, 3, 1'b1);
    expect_line("bp", 10);
    send_line(10'h011, 2, 3, 1'b1);
    expect_line("after_bp", 0);

    i_inj_addr_par_err = 1'b1;
    i_inj_data_par_err = 16'h0003;
    send_line(10'h200, 16, 2, 1'b1);
    i_inj_addr_par_err = 1'b0;
    i_inj_data_par_err = '0;
    chk("inj_dpar_const", o_data_parity, 16'hfffc);
    expect_line("inj", 1);
    send_line(10'h200, 16, 2, 1'b0);
    chk("clean_dpar_const", o_data_parity, 16'hffff);
    expect_line("clean", 0);

    send_beat(32'hdead_beef, 1'b0, 1'b0, 10'h3ff);
    send_line(10'h0f0, 2, 3, 1'b0);
    send_line(10'h10f, 4, 3, 1'b1);
    chk("proto_cnt", o_proto_err_cnt, 2);
    expect_line("restart", 0);

    send_line(10'h155, 5, 3, 1'b0);
    async_reset("rst_fill");
    send_line(10'h2aa, 16, 3, 1'b0);
    chk("pre_rst_pend", o_wr_valid, 1);
    async_reset("rst_pend");
    send_line(10'h07e, 7, 3, 1'b1);
    expect_line("post_rst", 2);

    for (int l = 0; l < 25; l++) begin
      int len;
      len = $urandom_range(1, BPL);
      i_inj_addr_par_err = ($urandom_range(0, 3) == 0);
      i_inj_data_par_err = ($urandom_range(0, 3) == 0) ? BPL'($urandom) : '0;
      if ($urandom_range(0, 4) == 0) send_beat($urandom, 1'b0, 1'b1, 10'h0);
      if ($urandom_range(0, 4) == 0) send_line(AW'($urandom), $urandom_range(1, 8), 3, 1'b0);
      send_line(AW'($urandom), len, 3, (len < BPL) ? 1'b1 : 1'($urandom));
      i_inj_addr_par_err = 1'b0;
      i_inj_data_par_err = '0;
      expect_line("rand", $urandom_range(0, 3));
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
